// File: rtl/hazard_scoreboard_unit.sv
// Load-use / branch hazard detection with a shift-register load tracker,
// memory wait-state freeze and a saturating stall-cycle counter.
module hazard_scoreboard_unit #(
    parameter int unsigned REG_AW       = 5,
    parameter int unsigned LOAD_LAT     = 1,
    parameter bit          BRANCH_IN_ID = 1'b0,
    parameter int unsigned CNT_W        = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [5:0]        Op_i,
    input  logic [REG_AW-1:0] IFID_RsAddr_i,
    input  logic [REG_AW-1:0] IFID_RtAddr_i,
    input  logic [REG_AW-1:0] IDEX_RdAddr_i,
    input  logic              IDEX_RegWrite_i,
    input  logic              IDEX_MemRead_i,
    input  logic              mem_ready_i,
    input  logic              MEM_MemAccess_i,
    output logic              PC_stall_o,
    output logic              IFID_stall_o,
    output logic              IDEX_bubble_o,
    output logic              freeze_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;

    logic                  use_rs;
    logic                  use_rt;
    logic                  is_beq;
    logic                  ex_load;
    logic                  load_hz;
    logic                  br_hz;
    logic                  hazard;
    logic                  freeze;

    logic [LOAD_LAT-1:0]   vld_q;
    logic [LOAD_LAT-1:0]   vld_d;
    logic [REG_AW-1:0]     addr_q [LOAD_LAT];
    logic [REG_AW-1:0]     addr_d [LOAD_LAT];
    logic [CNT_W-1:0]      cnt_q;
    logic [CNT_W-1:0]      cnt_d;

    // Register $0 is hard-wired, so a zero source never creates a hazard.
    function automatic logic src_hit(
        input logic              urs,
        input logic              urt,
        input logic [REG_AW-1:0] rs,
        input logic [REG_AW-1:0] rt,
        input logic [REG_AW-1:0] a
    );
        return (urs && (|rs) && (rs == a)) ||
               (urt && (|rt) && (rt == a));
    endfunction

    always_comb begin
        use_rs = 1'b0;
        use_rt = 1'b0;
        unique case (Op_i)
            OP_RTYPE, OP_BEQ, OP_SW: begin
                use_rs = 1'b1;
                use_rt = 1'b1;
            end
            OP_ADDI, OP_LW: begin
                use_rs = 1'b1;
            end
            default: begin
                use_rs = 1'b0;
                use_rt = 1'b0;
            end
        endcase
    end

    assign is_beq  = BRANCH_IN_ID && (Op_i == OP_BEQ);
    assign ex_load = IDEX_MemRead_i & IDEX_RegWrite_i;
    assign freeze  = MEM_MemAccess_i & ~mem_ready_i;

    always_comb begin
        load_hz = ex_load &
                  src_hit(use_rs, use_rt, IFID_RsAddr_i,
                          IFID_RtAddr_i, IDEX_RdAddr_i);
        br_hz   = is_beq & IDEX_RegWrite_i &
                  src_hit(use_rs, use_rt, IFID_RsAddr_i,
                          IFID_RtAddr_i, IDEX_RdAddr_i);
        // The last stage is already forwardable to EX, but not yet to ID.
        for (int k = 0; k < int'(LOAD_LAT); k++) begin
            if (vld_q[k] &&
                src_hit(use_rs, use_rt, IFID_RsAddr_i,
                        IFID_RtAddr_i, addr_q[k])) begin
                if (k < int'(LOAD_LAT) - 1) begin
                    load_hz = 1'b1;
                end
                if (is_beq) begin
                    br_hz = 1'b1;
                end
            end
        end
    end

    assign hazard        = load_hz | br_hz;
    assign freeze_o      = freeze;
    assign PC_stall_o    = freeze | hazard;
    assign IFID_stall_o  = freeze | hazard;
    assign IDEX_bubble_o = ~freeze & hazard;
    assign stall_cnt_o   = cnt_q;

    always_comb begin
        vld_d  = vld_q;
        addr_d = addr_q;
        if (!freeze) begin
            vld_d[0]  = ex_load & (|IDEX_RdAddr_i);
            addr_d[0] = IDEX_RdAddr_i;
            for (int k = 1; k < int'(LOAD_LAT); k++) begin
                vld_d[k]  = vld_q[k-1];
                addr_d[k] = addr_q[k-1];
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (PC_stall_o && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            vld_q <= '0;
            for (int k = 0; k < int'(LOAD_LAT); k++) begin
                addr_q[k] <= '0;
            end
            cnt_q <= '0;
        end else begin
            vld_q  <= vld_d;
            addr_q <= addr_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Table-driven bench: five parameter variants share one stimulus stream;
// each row names the instance whose outputs it checks.
module tb_hazard_scoreboard_unit;

    localparam logic [5:0] RT   = 6'h00;
    localparam logic [5:0] BEQ  = 6'h04;
    localparam logic [5:0] SW   = 6'h2b;
    localparam logic [5:0] ADDI = 6'h08;
    localparam logic [5:0] LW   = 6'h23;
    localparam logic [5:0] J    = 6'h02;

    typedef struct {
        bit          rst;
        logic [5:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        bit          rw;
        bit          mr;
        bit          macc;
        bit          mrdy;
        int          dut;
        bit          e_pc;
        bit          e_bub;
        bit          e_frz;
        logic [31:0] e_cnt;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
    logic        mrdy;
    logic        macc;
    logic        pc   [5];
    logic        ifid [5];
    logic        bub  [5];
    logic        frz  [5];
    logic [31:0] cnt  [5];
    logic [31:0] c0, c1, c2, c3;
    logic [1:0]  c4;

    int errors = 0;
    int checks = 0;
    vec_t vecs[$];
    vec_t sb[$];

    assign cnt[0] = c0;
    assign cnt[1] = c1;
    assign cnt[2] = c2;
    assign cnt[3] = c3;
    assign cnt[4] = {30'b0, c4};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    hazard_scoreboard_unit #(.LOAD_LAT(1)) u0 (
        .clk_i(clk), .rst_i(rst_n), .Op_i(op),
        .IFID_RsAddr_i(rs), .IFID_RtAddr_i(rt),
        .IDEX_RdAddr_i(rd), .IDEX_RegWrite_i(rw),
        .IDEX_MemRead_i(mr), .mem_ready_i(mrdy),
        .MEM_MemAccess_i(macc), .PC_stall_o(pc[0]),
        .IFID_stall_o(ifid[0]), .IDEX_bubble_o(bub[0]),
        .freeze_o(frz[0]), .stall_cnt_o(c0)
    );

    hazard_scoreboard_unit #(.LOAD_LAT(3)) u1 (
        .clk_i(clk), .rst_i(rst_n), .Op_i(op),
        .IFID_RsAddr_i(rs), .IFID_RtAddr_i(rt),
        .IDEX_RdAddr_i(rd), .IDEX_RegWrite_i(rw),
        .IDEX_MemRead_i(mr), .mem_ready_i(mrdy),
        .MEM_MemAccess_i(macc), .PC_stall_o(pc[1]),
        .IFID_stall_o(ifid[1]), .IDEX_bubble_o(bub[1]),
        .freeze_o(frz[1]), .stall_cnt_o(c1)
    );

    hazard_scoreboard_unit #(.LOAD_LAT(2)) u2 (
        .clk_i(clk), .rst_i(rst_n), .Op_i(op),
        .IFID_RsAddr_i(rs), .IFID_RtAddr_i(rt),
        .IDEX_RdAddr_i(rd), .IDEX_RegWrite_i(rw),
        .IDEX_MemRead_i(mr), .mem_ready_i(mrdy),
        .MEM_MemAccess_i(macc), .PC_stall_o(pc[2]),
        .IFID_stall_o(ifid[2]), .IDEX_bubble_o(bub[2]),
        .freeze_o(frz[2]), .stall_cnt_o(c2)
    );

    hazard_scoreboard_unit #(.LOAD_LAT(1), .BRANCH_IN_ID(1'b1)) u3 (
        .clk_i(clk), .rst_i(rst_n), .Op_i(op),
        .IFID_RsAddr_i(rs), .IFID_RtAddr_i(rt),
        .IDEX_RdAddr_i(rd), .IDEX_RegWrite_i(rw),
        .IDEX_MemRead_i(mr), .mem_ready_i(mrdy),
        .MEM_MemAccess_i(macc), .PC_stall_o(pc[3]),
        .IFID_stall_o(ifid[3]), .IDEX_bubble_o(bub[3]),
        .freeze_o(frz[3]), .stall_cnt_o(c3)
    );

    hazard_scoreboard_unit #(.LOAD_LAT(1), .CNT_W(2)) u4 (
        .clk_i(clk), .rst_i(rst_n), .Op_i(op),
        .IFID_RsAddr_i(rs), .IFID_RtAddr_i(rt),
        .IDEX_RdAddr_i(rd), .IDEX_RegWrite_i(rw),
        .IDEX_MemRead_i(mr), .mem_ready_i(mrdy),
        .MEM_MemAccess_i(macc), .PC_stall_o(pc[4]),
        .IFID_stall_o(ifid[4]), .IDEX_bubble_o(bub[4]),
        .freeze_o(frz[4]), .stall_cnt_o(c4)
    );

    // st = hazard stall expected, fz = freeze expected (freeze wins).
    function automatic vec_t mk(
        int d, bit r, logic [5:0] o, int s, int t, int w,
        bit wr, bit rd_m, bit ma, bit rdy, bit st, bit fz, int c
    );
        vec_t v;
        v.dut   = d;
        v.rst   = r;
        v.op    = o;
        v.rs    = 5'(s);
        v.rt    = 5'(t);
        v.rd    = 5'(w);
        v.rw    = wr;
        v.mr    = rd_m;
        v.macc  = ma;
        v.mrdy  = rdy;
        v.e_pc  = st | fz;
        v.e_bub = st & ~fz;
        v.e_frz = fz;
        v.e_cnt = 32'(c);
        return v;
    endfunction

    function automatic vec_t rst_row(int d);
        return mk(d, 0, J, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    endfunction

    task automatic chk(string nm, int row, logic [31:0] act,
                       logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %0h want %0h",
                     nm, row, act, exp);
        end
    endtask

    initial begin
        // reset state and LOAD_LAT=1 load-use
        vecs.push_back(rst_row(0));
        vecs.push_back(mk(0, 1, ADDI, 8, 0, 8, 1, 1, 0, 1, 1, 0, 0));
        vecs.push_back(mk(0, 1, ADDI, 8, 0, 0, 0, 0, 0, 1, 0, 0, 1));
        vecs.push_back(mk(0, 1, J,    0, 0, 0, 0, 0, 0, 1, 0, 0, 1));
        // source decode, forwarding cases, beq with BRANCH_IN_ID=0
        vecs.push_back(rst_row(0));
        vecs.push_back(mk(0, 1, ADDI, 1, 8, 8, 1, 1, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, SW,   1, 8, 8, 1, 1, 0, 1, 1, 0, 0));
        vecs.push_back(mk(0, 1, J,    8, 8, 8, 1, 1, 0, 1, 0, 0, 1));
        vecs.push_back(mk(0, 1, LW,   8, 8, 8, 1, 1, 0, 1, 1, 0, 1));
        vecs.push_back(mk(0, 1, RT,   4, 9, 4, 1, 0, 0, 1, 0, 0, 2));
        vecs.push_back(mk(0, 1, BEQ,  4, 9, 4, 1, 0, 0, 1, 0, 0, 2));
        vecs.push_back(mk(0, 1, BEQ,  2, 7, 7, 1, 1, 0, 1, 1, 0, 2));
        vecs.push_back(mk(0, 1, BEQ,  2, 7, 0, 0, 0, 0, 1, 0, 0, 3));
        vecs.push_back(mk(0, 1, RT,   8, 0, 8, 0, 1, 0, 1, 0, 0, 3));
        // lw $0 never matches
        vecs.push_back(rst_row(0));
        vecs.push_back(mk(0, 1, RT,   0, 0, 0, 1, 1, 0, 1, 0, 0, 0));
        vecs.push_back(mk(1, 1, RT,   0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        // LOAD_LAT=3: three stall cycles
        vecs.push_back(rst_row(1));
        vecs.push_back(mk(1, 1, RT,   1, 9, 9, 1, 1, 0, 1, 1, 0, 0));
        vecs.push_back(mk(1, 1, RT,   1, 9, 0, 0, 0, 0, 1, 1, 0, 1));
        vecs.push_back(mk(1, 1, RT,   1, 9, 0, 0, 0, 0, 1, 1, 0, 2));
        vecs.push_back(mk(1, 1, RT,   1, 9, 0, 0, 0, 0, 1, 0, 0, 3));
        // LOAD_LAT=2: freeze over a pending hazard
        vecs.push_back(rst_row(2));
        vecs.push_back(mk(2, 1, J,    0, 0, 5, 1, 1, 0, 1, 0, 0, 0));
        vecs.push_back(mk(2, 1, ADDI, 5, 0, 0, 0, 0, 1, 0, 0, 1, 0));
        vecs.push_back(mk(2, 1, ADDI, 5, 0, 0, 0, 0, 1, 0, 0, 1, 1));
        vecs.push_back(mk(2, 1, ADDI, 5, 0, 0, 0, 0, 1, 1, 1, 0, 2));
        vecs.push_back(mk(2, 1, ADDI, 5, 0, 0, 0, 0, 1, 1, 0, 0, 3));
        vecs.push_back(mk(2, 1, J,    0, 0, 0, 0, 0, 0, 0, 0, 0, 3));
        // BRANCH_IN_ID=1
        vecs.push_back(rst_row(3));
        vecs.push_back(mk(3, 1, BEQ,  4, 1, 4, 1, 0, 0, 1, 1, 0, 0));
        vecs.push_back(mk(3, 1, BEQ,  4, 1, 0, 0, 0, 0, 1, 0, 0, 1));
        vecs.push_back(mk(3, 1, BEQ,  2, 7, 7, 1, 1, 0, 1, 1, 0, 1));
        vecs.push_back(mk(3, 1, BEQ,  2, 7, 0, 0, 0, 0, 1, 1, 0, 2));
        vecs.push_back(mk(3, 1, BEQ,  2, 7, 0, 0, 0, 0, 1, 0, 0, 3));
        vecs.push_back(mk(3, 1, RT,   4, 0, 4, 1, 0, 0, 1, 0, 0, 3));
        // reset in the middle of a LOAD_LAT=3 stall
        vecs.push_back(rst_row(1));
        vecs.push_back(mk(1, 1, RT,   3, 1, 3, 1, 1, 0, 1, 1, 0, 0));
        vecs.push_back(mk(1, 1, RT,   3, 1, 0, 0, 0, 0, 1, 1, 0, 1));
        vecs.push_back(mk(1, 0, RT,   3, 1, 0, 0, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, RT,   3, 1, 3, 1, 1, 0, 1, 1, 0, 0));
        vecs.push_back(mk(1, 1, RT,   3, 1, 0, 0, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(1, 1, RT,   3, 1, 0, 0, 0, 0, 1, 0, 0, 0));
        // 2-bit counter saturation
        vecs.push_back(rst_row(4));
        vecs.push_back(mk(4, 1, J,    0, 0, 0, 0, 0, 1, 0, 0, 1, 0));
        vecs.push_back(mk(4, 1, J,    0, 0, 0, 0, 0, 1, 0, 0, 1, 1));
        vecs.push_back(mk(4, 1, J,    0, 0, 0, 0, 0, 1, 0, 0, 1, 2));
        vecs.push_back(mk(4, 1, J,    0, 0, 0, 0, 0, 1, 0, 0, 1, 3));
        vecs.push_back(mk(4, 1, J,    0, 0, 0, 0, 0, 1, 0, 0, 1, 3));
        vecs.push_back(mk(4, 1, J,    0, 0, 0, 0, 0, 1, 1, 0, 0, 3));

        rst_n = 1'b0;
        op    = J;
        rs    = '0;
        rt    = '0;
        rd    = '0;
        rw    = 1'b0;
        mr    = 1'b0;
        mrdy  = 1'b1;
        macc  = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            vec_t e;
            @(negedge clk);
            rst_n = vecs[i].rst;
            op    = vecs[i].op;
            rs    = vecs[i].rs;
            rt    = vecs[i].rt;
            rd    = vecs[i].rd;
            rw    = vecs[i].rw;
            mr    = vecs[i].mr;
            macc  = vecs[i].macc;
            mrdy  = vecs[i].mrdy;
            sb.push_back(vecs[i]);
            #1;
            e = sb.pop_front();
            chk("pc_stall",   i, 32'(pc[e.dut]),   32'(e.e_pc));
            chk("ifid_stall", i, 32'(ifid[e.dut]), 32'(e.e_pc));
            chk("bubble",     i, 32'(bub[e.dut]),  32'(e.e_bub));
            chk("freeze",     i, 32'(frz[e.dut]),  32'(e.e_frz));
            chk("stall_cnt",  i, cnt[e.dut],       e.e_cnt);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard_unit.md
Name: hazard_scoreboard_unit

Overview:
Hazard detection for the 5-stage MIPS pipeline, supporting a parametrised load-to-use latency and an optional branch-resolve-in-ID mode.
- A shift-register scoreboard tracks load destinations for LOAD_LAT cycles after they leave EX, and stalls ID consumers until the data can be forwarded.
- Data-memory wait states (mem_ready_i) freeze the whole pipeline.
- A saturating stall-cycle counter provides performance monitoring.

Parameters:
REG_AW, 5, register address width
LOAD_LAT, 1, cycles after EX until load data is forwardable to a consumer in EX (>=1)
BRANCH_IN_ID, 0, 1 = beq compares in ID, which requires extra stalls on EX/load producers
CNT_W, 32, stall counter width

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, asynchronous, active-low
Op_i  in  6  opcode of instruction in ID
IFID_RsAddr_i  in  REG_AW  rs of ID instruction
IFID_RtAddr_i  in  REG_AW  rt of ID instruction
IDEX_RdAddr_i  in  REG_AW  final destination register of EX instruction (already muxed rt/rd)
IDEX_RegWrite_i  in  1  EX instruction writes a register
IDEX_MemRead_i  in  1  EX instruction is a load
mem_ready_i  in  1  data memory ready; low = wait state for load/store in MEM
MEM_MemAccess_i  in  1  MEM-stage instruction is a load or store
PC_stall_o  out  1  hold PC
IFID_stall_o  out  1  hold IF/ID register
IDEX_bubble_o  out  1  load zeros (nop) into ID/EX
freeze_o  out  1  hold ID/EX, EX/MEM, MEM/WB and the tracker
stall_cnt_o  out  CNT_W  cycles with PC_stall_o high, saturating

Behaviour:
- Source use decoded from Op_i:
  - 000000 (R-type), 000100 (beq), 101011 (sw): rs and rt.
  - 001000 (addi), 100011 (lw): rs only.
  - All other opcodes use no sources.
- A used source equal to 0 never matches.
- Tracker: LOAD_LAT stages, each holding {valid, addr}.
  - Stage 1 is the load that left EX last cycle; stage k+1 is the previous contents of stage k.
  - Stage 1 loads valid = IDEX_MemRead_i & IDEX_RegWrite_i & (IDEX_RdAddr_i != 0), addr = IDEX_RdAddr_i.
  - Stage k+1 loads stage k; the last stage's contents are discarded.
  - The tracker advances every cycle freeze_o = 0 and holds all entries when freeze_o = 1.
  - The tracker is cleared asynchronously on reset.
- Load hazard (all consumers) when a used source matches either:
  - an EX load (IDEX_MemRead_i & IDEX_RegWrite_i), or
  - a valid tracker stage k with k < LOAD_LAT.
- Branch hazard (only when BRANCH_IN_ID = 1 and Op_i = beq) when a used source matches any of:
  - the EX writer (IDEX_RegWrite_i) of any kind,
  - a valid tracker stage k with k <= LOAD_LAT.
- Resulting stall lengths:
  - Normal consumer directly after a load: LOAD_LAT stall cycles.
  - beq (BRANCH_IN_ID = 1): LOAD_LAT+1 cycles after a load, 1 cycle after an ALU writer.
- freeze_o = MEM_MemAccess_i & ~mem_ready_i. Combinational, takes priority.
- Output priority:
  - freeze_o = 1: PC_stall_o = IFID_stall_o = 1, IDEX_bubble_o = 0.
  - Else, hazard: PC_stall_o = IFID_stall_o = IDEX_bubble_o = 1.
  - Else: all 0.
- All stall, bubble and freeze outputs are combinational from inputs and the tracker (0-cycle latency).
- stall_cnt_o:
  - Increments on each rising edge where PC_stall_o = 1.
  - Saturates at all-ones.
  - Async reset to 0.
- Reset (rst_i = 0):
  - Tracker invalid and stall_cnt_o = 0 immediately, including mid-stall.
  - Outputs are then determined by the inputs only: tracker-based stalls vanish at once; EX-load matches still stall.
- A hazard and a freeze in the same cycle: freeze wins. The hazard is re-evaluated after the freeze releases; the tracker has not moved, so no stall cycle is lost or duplicated.
- BRANCH_IN_ID = 0: beq behaves as a normal rs/rt consumer.

Test Plan:
- LOAD_LAT=1: lw $8 in EX, addi rs=8 in ID -> 1 cycle of PC_stall/IFID_stall/IDEX_bubble = 1, released next cycle, stall_cnt_o = 1.
- LOAD_LAT=3: lw $9 in EX, R-type rt=9 held in ID -> exactly 3 consecutive stall cycles, then 0; stall_cnt_o = 3.
- lw $0 in EX, add rs=0 rt=0 in ID -> no stall; tracker stage 1 stays invalid.
- LOAD_LAT=2: lw $5 enters tracker; mem_ready_i low 2 cycles with MEM_MemAccess_i = 1 -> freeze_o = 1 and bubble = 0 for 2 cycles, tracker unchanged. Then a consumer of $5 stalls 1 cycle; stall_cnt_o = 3.
- BRANCH_IN_ID=1, LOAD_LAT=1: beq rs=4 after add $4 -> 1 stall; beq rt=7 after lw $7 -> 2 stalls.
- LOAD_LAT=3: rst_i low in the 2nd stall cycle after lw $3 (lw gone from EX) -> all outputs 0 and stall_cnt_o = 0 immediately; no stall after rst_i returns high.
